// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl
// Sequences MEM-stage data-memory accesses onto a valid/ready request and
// response bus. A load or store seen in IDLE is latched, issued on the bus,
// and the pipeline is held with stall_o until the response (or a timeout)
// completes the access. Loads return the raw read word on rdata_o.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   mem_read_i      MEM-stage load request
//   web_i           active-low byte write enables (any 0 bit = store)
//   addr_i, wdata_i access address and aligned store data
//   stall_o         hold IF..MEM pipeline registers
//   rdata_o         last captured load word
//   err_o           one-cycle pulse in DONE on bus error or timeout
//   req_*           bus request channel (valid/ready with latched fields)
//   rsp_*           bus response channel
module dm_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read_i,
    input  logic [DATA_W/8-1:0] web_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                stall_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o,
    output logic                req_valid_o,
    input  logic                req_ready_i,
    output logic                req_write_o,
    output logic [ADDR_W-1:0]   req_addr_o,
    output logic [DATA_W-1:0]   req_wdata_o,
    output logic [DATA_W/8-1:0] req_wstrb_o,
    input  logic                rsp_valid_i,
    input  logic [DATA_W-1:0]   rsp_rdata_i,
    input  logic                rsp_err_i
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                write_q;
    logic                err_q;
    logic [7:0]          wait_cnt;
    logic [DATA_W-1:0]   rdata_q;

    logic is_store;
    logic access;

    // A store wins when both a load and a store are requested.
    assign is_store = ~&web_i;
    assign access   = mem_read_i | is_store;

    // Main FSM. Only IDLE looks at the MEM-stage inputs; once latched, the
    // bus is driven purely from the captured fields so they stay stable
    // while the request waits for ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
                        wdata_q <= wdata_i;
                        write_q <= is_store;
                        wstrb_q <= is_store ? ~web_i : '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (req_ready_i) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    // A response takes priority over a timeout in the same cycle.
                    if (rsp_valid_i) begin
                        if (!write_q) begin
                            rdata_q <= rsp_rdata_i;
                        end
                        err_q <= rsp_err_i;
                        state <= DONE;
                    end else if (wait_cnt + 8'd1 == TIMEOUT_CNT) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Always pass through IDLE so the next instruction is
                    // sampled fresh after the pipeline advances.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // IDLE stalls immediately on a new access so the instruction is held
    // in MEM from its first cycle; DONE releases the pipeline.
    always_comb begin
        stall_o = 1'b0;
        case (state)
            IDLE:    stall_o = access;
            REQ:     stall_o = 1'b1;
            WAIT:    stall_o = 1'b1;
            DONE:    stall_o = 1'b0;
            default: stall_o = 1'b0;
        endcase
    end

    assign err_o       = (state == DONE) && err_q;
    assign rdata_o     = rdata_q;
    assign req_valid_o = (state == REQ);
    assign req_write_o = write_q;
    assign req_addr_o  = addr_q;
    assign req_wdata_o = wdata_q;
    assign req_wstrb_o = wstrb_q;

endmodule
